// File: rtl/nco_sweep_ctrl.sv
// Sweep sequencer for the NCO ctrl trim: steps ctrl from a start value to a stop
// value with a per-value dwell, in single, repeat or triangle mode.
module nco_sweep_ctrl #(
  parameter int CTRL_W  = 24,
  parameter int DWELL_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic signed [CTRL_W-1:0] start_val,
  input  logic signed [CTRL_W-1:0] stop_val,
  input  logic [CTRL_W-1:0]        step,
  input  logic [DWELL_W-1:0]       dwell,
  output logic signed [CTRL_W-1:0] ctrl,
  output logic                     busy,
  output logic                     done,
  output logic                     step_strobe,
  output logic                     dir,
  output logic                     dbg_state
);

  // Request handshake: start and abort are single-cycle requests taken on any
  // enabled edge (ena=1); there is no ready. Abort has priority over start, and
  // start is only taken in IDLE. Nothing is accepted while ena=0.

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // Two guard bits: an unsigned full-scale step added to a full-scale ctrl
  // still fits without wrapping.
  localparam int XW = CTRL_W + 2;

  state_t                     r_state;
  logic signed [CTRL_W-1:0]   r_ctrl;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_strobe;
  logic                       r_dir;
  logic [DWELL_W-1:0]         r_cnt;
  logic [1:0]                 r_mode;
  logic signed [CTRL_W-1:0]   r_start;
  logic signed [CTRL_W-1:0]   r_stop;
  logic [CTRL_W-1:0]          r_step;
  logic [DWELL_W-1:0]         r_dwell;
  logic                       r_to_stop;

  logic signed [CTRL_W-1:0]   w_target;
  logic signed [CTRL_W-1:0]   w_turn_target;
  logic signed [CTRL_W-1:0]   w_adv;
  logic signed [CTRL_W-1:0]   w_turn;

  function automatic logic signed [CTRL_W-1:0] advance(
    input logic signed [CTRL_W-1:0] cur,
    input logic signed [CTRL_W-1:0] tgt,
    input logic [CTRL_W-1:0]        stp,
    input logic                     desc
  );
    logic signed [XW-1:0] x_cur;
    logic signed [XW-1:0] x_tgt;
    logic signed [XW-1:0] x_stp;
    logic signed [XW-1:0] x_nxt;
    logic                 reached;
    x_cur   = {{2{cur[CTRL_W-1]}}, cur};
    x_tgt   = {{2{tgt[CTRL_W-1]}}, tgt};
    x_stp   = {2'b00, stp};
    x_nxt   = desc ? (x_cur - x_stp) : (x_cur + x_stp);
    reached = desc ? (x_nxt <= x_tgt) : (x_nxt >= x_tgt);
    return reached ? tgt : CTRL_W'(x_nxt);
  endfunction

  assign w_target      = r_to_stop ? r_stop : r_start;
  assign w_turn_target = r_to_stop ? r_start : r_stop;
  assign w_adv         = advance(r_ctrl, w_target, r_step, r_dir);
  assign w_turn        = advance(r_ctrl, w_turn_target, r_step, ~r_dir);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_strobe  <= 1'b0;
      r_dir     <= 1'b0;
      r_cnt     <= '0;
      r_mode    <= '0;
      r_start   <= '0;
      r_stop    <= '0;
      r_step    <= '0;
      r_dwell   <= '0;
      r_to_stop <= 1'b0;
    end else if (ena) begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_mode    <= mode;
              r_start   <= start_val;
              r_stop    <= stop_val;
              r_step    <= (step == '0) ? CTRL_W'(1) : step;
              r_dwell   <= dwell;
              r_ctrl    <= start_val;
              r_strobe  <= 1'b1;
              r_busy    <= 1'b1;
              r_cnt     <= dwell;
              r_dir     <= (stop_val < start_val);
              r_to_stop <= 1'b1;
              r_state   <= S_RUN;
            end
          end
          S_RUN: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - DWELL_W'(1);
            end else if (r_ctrl != w_target) begin
              r_ctrl   <= w_adv;
              r_strobe <= 1'b1;
              r_cnt    <= r_dwell;
            end else begin
              case (r_mode)
                2'd1: begin
                  r_ctrl   <= r_start;
                  r_strobe <= 1'b1;
                  r_cnt    <= r_dwell;
                end
                2'd2: begin
                  // Turn around and take the first step of the new leg now.
                  r_to_stop <= ~r_to_stop;
                  r_dir     <= ~r_dir;
                  r_ctrl    <= w_turn;
                  r_strobe  <= 1'b1;
                  r_cnt     <= r_dwell;
                end
                default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              endcase
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ctrl        = r_ctrl;
  assign busy        = r_busy;
  assign done        = r_done;
  assign step_strobe = r_strobe;
  assign dir         = r_dir;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed test-plan scenarios plus randomized traffic,
// every cycle compared against a value-queue reference model.
module tb_nco_sweep_ctrl;
  localparam int CW = 24;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ena;
  logic                 start;
  logic                 abort;
  logic [1:0]           mode;
  logic signed [CW-1:0] start_val;
  logic signed [CW-1:0] stop_val;
  logic [CW-1:0]        step;
  logic [DW-1:0]        dwell;
  logic signed [CW-1:0] ctrl;
  logic                 busy;
  logic                 done;
  logic                 step_strobe;
  logic                 dir;
  logic                 dbg_state;

  nco_sweep_ctrl #(.CTRL_W(CW), .DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
    .mode(mode), .start_val(start_val), .stop_val(stop_val), .step(step),
    .dwell(dwell), .ctrl(ctrl), .busy(busy), .done(done),
    .step_strobe(step_strobe), .dir(dir), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  longint seen_q[$];
  logic [CW-1:0] exp_q[$];   // values still to be visited on the current leg

  longint m_ctrl = 0;
  bit     m_busy = 0, m_done = 0, m_strobe = 0, m_dir = 0, m_to_stop = 0;
  int     m_hold = 0;
  int     c_mode = 0, c_dwell = 0;
  longint c_start = 0, c_stop = 0, c_step = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [CW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clamp_step(input longint cur, input longint tgt, input longint stp);
    longint nxt;
    if (tgt < cur) begin
      nxt = cur - stp;
      return (nxt <= tgt) ? tgt : nxt;
    end
    nxt = cur + stp;
    return (nxt >= tgt) ? tgt : nxt;
  endfunction

  // Every value from one step after 'from' up to and including 'to'; at least one.
  task automatic fill_leg(input longint from, input longint to);
    longint v;
    v = from;
    do begin
      v = clamp_step(v, to, c_step);
      exp_q.push_back(v[CW-1:0]);
    end while (v != to);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ctrl = 0; m_busy = 0; m_done = 0; m_strobe = 0; m_dir = 0; m_hold = 0;
      exp_q.delete();
    end else if (ena) begin
      m_strobe = 0;
      m_done   = 0;
      if (abort) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (start) begin
          c_mode  = int'(mode);
          c_start = longint'(start_val);
          c_stop  = longint'(stop_val);
          c_step  = (step == 0) ? 1 : longint'(step);
          c_dwell = int'(dwell);
          exp_q.delete();
          m_ctrl = c_start; m_strobe = 1; m_busy = 1; m_hold = c_dwell;
          m_dir = (c_stop < c_start); m_to_stop = 1;
          if (c_start != c_stop) fill_leg(c_start, c_stop);
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (exp_q.size() > 0) begin
        m_ctrl = sx(exp_q.pop_front()); m_strobe = 1; m_hold = c_dwell;
      end else if (c_mode == 1) begin
        m_ctrl = c_start; m_strobe = 1; m_hold = c_dwell;
        if (c_start != c_stop) fill_leg(c_start, c_stop);
      end else if (c_mode == 2) begin
        m_dir = !m_dir;
        m_to_stop = !m_to_stop;
        fill_leg(m_ctrl, m_to_stop ? c_stop : c_start);
        m_ctrl = sx(exp_q.pop_front()); m_strobe = 1; m_hold = c_dwell;
      end else begin
        m_busy = 0; m_done = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_eq("ctrl", ctrl[CW-1:0], m_ctrl[CW-1:0]);
    check_eq("busy", busy, m_busy);
    check_eq("done", done, m_done);
    check_eq("strobe", step_strobe, m_strobe);
    check_eq("dir", dir, m_dir);
    check_eq("state", dbg_state, m_busy);
    if (step_strobe) seen_q.push_back(longint'(ctrl));
    if (done) done_cnt++;
  endtask

  task automatic set_cfg(input int md, input longint sv, input longint ev, input longint st, input int dw);
    mode      = md[1:0];
    start_val = sv[CW-1:0];
    stop_val  = ev[CW-1:0];
    step      = st[CW-1:0];
    dwell     = dw[DW-1:0];
  endtask

  task automatic pulse_start();
    seen_q.delete();
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // n counts cycles since the accepting edge; cycle t+1 is n=1.
  task automatic run_to_done(input int n0, input int maxc, output int n);
    n = n0;
    while (!done && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic check_trace(input string tag, input longint exp_vals[$]);
    check_eq({tag, "_count"}, seen_q.size(), exp_vals.size());
    for (int i = 0; i < exp_vals.size() && i < seen_q.size(); i++)
      check_eq(tag, 32'(seen_q[i]), 32'(exp_vals[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int k;
    longint tri_pat[4];
    longint b;
    longint sv;
    longint ev;
    longint st;

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) tick();
    check_eq("rst_ctrl", ctrl[CW-1:0], 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flags", {done, step_strobe, dir}, 0);
    rst_n = 1'b1;
    tick();

    // single ascending
    set_cfg(0, 0, 40, 10, 2);
    pulse_start();
    check_eq("single_busy_t1", busy, 1);
    run_to_done(1, 100, n);
    check_eq("single_lat", n, 16);
    check_eq("single_busy_end", busy, 0);
    check_trace("single_val", '{0, 10, 20, 30, 40});
    tick(); tick();
    check_eq("single_hold", ctrl[CW-1:0], 40);
    check_eq("single_done_once", done_cnt, 1);

    // clamp and descending, mode 3 also means single
    set_cfg(3, 100, -50, 60, 0);
    pulse_start();
    check_eq("desc_dir", dir, 1);
    run_to_done(1, 100, n);
    check_eq("desc_lat", n, 5);
    check_trace("desc_val", '{100, 40, -20, -50});

    // repeat
    set_cfg(1, 0, 20, 10, 0);
    pulse_start();
    repeat (11) tick();
    for (int i = 0; i < 12 && i < seen_q.size(); i++)
      check_eq("repeat_val", 32'(seen_q[i]), 32'((i % 3) * 10));
    check_eq("repeat_no_done", done_cnt, 0);
    pulse_abort();
    check_eq("repeat_abort_busy", busy, 0);

    // triangle
    tri_pat = '{0, 10, 20, 10};
    set_cfg(2, 0, 20, 10, 0);
    pulse_start();
    repeat (15) tick();
    check_eq("tri_count", seen_q.size(), 16);
    for (int i = 0; i < 16 && i < seen_q.size(); i++)
      check_eq("tri_val", 32'(seen_q[i]), 32'(tri_pat[i % 4]));
    check_eq("tri_no_done", done_cnt, 0);
    pulse_abort();

    // extremes
    set_cfg(0, 'h7FFFF0, 'h7FFFFF, 'h100, 0);
    pulse_start();
    run_to_done(1, 100, n);
    check_eq("ext_lat", n, 3);
    check_trace("ext_val", '{'h7FFFF0, 'h7FFFFF});

    // triangle with start == stop keeps strobing the same value
    set_cfg(2, -7, -7, 5, 1);
    pulse_start();
    repeat (9) tick();
    check_eq("tri_eq_strobes", seen_q.size(), 5);
    check_eq("tri_eq_ctrl", ctrl[CW-1:0], 24'hFFFFF9);
    pulse_abort();

    // abort at third value
    set_cfg(0, 0, 40, 10, 2);
    pulse_start();
    k = 0;
    while (seen_q.size() < 3 && k < 50) begin
      tick();
      k++;
    end
    check_eq("abort_reach3", seen_q.size(), 3);
    pulse_abort();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ctrl", ctrl[CW-1:0], 20);
    repeat (20) tick();
    check_eq("abort_no_done", done_cnt, 0);

    // start and abort together in IDLE
    start = 1'b1;
    pulse_abort();
    start = 1'b0;
    check_eq("collide_busy", busy, 0);
    check_eq("collide_ctrl", ctrl[CW-1:0], 20);

    // start during RUN is ignored, as are config changes
    set_cfg(0, 0, 40, 10, 2);
    pulse_start();
    repeat (3) tick();
    set_cfg(1, -500, 500, 1, 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(5, 100, n);
    check_eq("ignore_lat", n, 16);
    check_trace("ignore_val", '{0, 10, 20, 30, 40});

    // enable stall mid-dwell
    set_cfg(0, 0, 40, 10, 2);
    pulse_start();
    tick();
    ena = 1'b0;
    repeat (5) tick();
    check_eq("stall_ctrl", ctrl[CW-1:0], 0);
    ena = 1'b1;
    run_to_done(7, 100, n);
    check_eq("stall_lat", n, 21);

    // reset mid-run
    set_cfg(0, 100, -50, 20, 1);
    pulse_start();
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    check_eq("midrst_ctrl", ctrl[CW-1:0], 0);
    check_eq("midrst_flags", {busy, done, step_strobe, dir}, 0);
    rst_n = 1'b1;
    tick();

    // randomized traffic, model checked every cycle
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      ena   = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0:       b = 0;
        1:       b = 64'sd8388607 - 160;
        default: b = -64'sd8388608 + 160;
      endcase
      sv = b + longint'($urandom_range(0, 300)) - 150;
      ev = b + longint'($urandom_range(0, 300)) - 150;
      if ($urandom_range(0, 4) == 0) ev = -sv;
      st = ($urandom_range(0, 9) == 0) ? longint'($urandom_range(0, 24'hFFFFFF))
                                       : longint'($urandom_range(0, 80));
      set_cfg(int'($urandom_range(0, 3)), sv, ev, st, int'($urandom_range(0, 3)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
